btree_search: RTL and testbench



---
 rtl/btree_search.sv | 113 +++++++++++
 tb/tb_btree_search.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/btree_search.sv
// btree_search: walks a B-tree held in a combinational node bank, one level
// per clock, from the root until the key is found, a null child is reached
// or the depth limit is exhausted.
module btree_search #(
  parameter int pKeyWidth  = 4,
  parameter int pDataWidth = 4,
  parameter int pNodeWidth = 8,
  parameter int pAddrWidth = 16,
  parameter int pRoot      = 1,
  parameter int pMaxDepth  = 8,
  localparam int CW        = $clog2(pMaxDepth + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [pKeyWidth-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [pDataWidth-1:0] data,
  output logic [CW-1:0]         steps,
  output logic                  overflow,
  output logic [pKeyWidth-1:0]  idxKey,
  output logic [pAddrWidth-1:0] idxAddress,
  input  logic                  idxFound,
  input  logic [pDataWidth-1:0] idxData,
  input  logic [pNodeWidth-1:0] idxNode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0]         MAX_DEPTH = CW'(pMaxDepth);
  localparam logic [pAddrWidth-1:0] ROOT_ADDR = pAddrWidth'(pRoot);

  state_t                  state;
  state_t                  state_next;
  logic [pKeyWidth-1:0]    key_q;
  logic [pAddrWidth-1:0]   addr_q;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_inc;
  logic                    accept;
  logic                    null_child;
  logic                    depth_hit;

  assign count_inc  = count + CW'(1);
  assign null_child = (idxNode == '0);
  assign depth_hit  = (count_inc == MAX_DEPTH);
  assign accept     = start && (state != PROBE);

  assign busy       = (state == PROBE);
  assign done       = (state == DONE);
  assign idxKey     = busy ? key_q  : '0;
  assign idxAddress = busy ? addr_q : '0;

  // State register; reset aborts any search in flight without a done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: a search ends on a hit, a null child or the depth limit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PROBE;
      PROBE:   if (idxFound || null_child || depth_hit) state_next = DONE;
      DONE:    state_next = start ? PROBE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Search datapath: latch the request, follow child pointers, record results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_q    <= '0;
      addr_q   <= '0;
      count    <= '0;
      found    <= 1'b0;
      data     <= '0;
      steps    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      key_q  <= key;
      addr_q <= ROOT_ADDR;
      count  <= '0;
    end else if (state == PROBE) begin
      if (idxFound) begin
        found    <= 1'b1;
        data     <= idxData;
        steps    <= count_inc;
        overflow <= 1'b0;
      end else if (null_child) begin
        found    <= 1'b0;
        data     <= '0;
        steps    <= count_inc;
        overflow <= 1'b0;
      end else if (depth_hit) begin
        found    <= 1'b0;
        data     <= '0;
        steps    <= MAX_DEPTH;
        overflow <= 1'b1;
      end else begin
        addr_q <= pAddrWidth'(idxNode);
        count  <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_btree_search.sv
// tb_btree_search: directed checks of btree_search against a small fixed tree.
module tb_btree_search;

  logic        clock;
  logic        reset;
  logic        start, start2;
  logic [7:0]  key, key2;
  logic        busy, done, found, overflow;
  logic [3:0]  data, steps;
  logic [7:0]  idx_key;
  logic [15:0] idx_address;
  logic        idx_found;
  logic [3:0]  idx_data;
  logic [7:0]  idx_node;
  logic        busy2, done2, found2, overflow2;
  logic [3:0]  data2, steps2;
  logic [7:0]  idx_key2;
  logic [15:0] idx_address2;
  logic        idx_found2;
  logic [3:0]  idx_data2;
  logic [7:0]  idx_node2;
  int          checks   = 0;
  int          failures = 0;

  btree_search #(.pKeyWidth(8), .pDataWidth(4), .pNodeWidth(8), .pAddrWidth(16),
                 .pRoot(1), .pMaxDepth(8)) dut (
    .clock(clock), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done), .found(found), .data(data), .steps(steps),
    .overflow(overflow), .idxKey(idx_key), .idxAddress(idx_address),
    .idxFound(idx_found), .idxData(idx_data), .idxNode(idx_node));

  btree_search #(.pKeyWidth(8), .pDataWidth(4), .pNodeWidth(8), .pAddrWidth(16),
                 .pRoot(6), .pMaxDepth(8)) dut_ovf (
    .clock(clock), .reset(reset), .start(start2), .key(key2),
    .busy(busy2), .done(done2), .found(found2), .data(data2), .steps(steps2),
    .overflow(overflow2), .idxKey(idx_key2), .idxAddress(idx_address2),
    .idxFound(idx_found2), .idxData(idx_data2), .idxNode(idx_node2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Node bank model of the fixed test tree.
  task automatic bank(input logic [15:0] a, input logic [7:0] k,
                      output logic f, output logic [3:0] d, output logic [7:0] n);
    f = 1'b0; d = 4'd0; n = 8'd0;
    case (a)
      16'd1: begin
        if      (k == 8'd10) begin f = 1'b1; d = 4'd1; end
        else if (k == 8'd20) begin f = 1'b1; d = 4'd2; end
        else if (k == 8'd30) begin f = 1'b1; d = 4'd3; end
        else if (k < 8'd10)  n = 8'd2;
        else if (k < 8'd20)  n = 8'd3;
        else if (k < 8'd30)  n = 8'd4;
        else                 n = 8'd5;
      end
      16'd3: begin
        if      (k == 8'd12) begin f = 1'b1; d = 4'd7; end
        else if (k == 8'd15) begin f = 1'b1; d = 4'd8; end
        else if (k == 8'd18) begin f = 1'b1; d = 4'd9; end
      end
      16'd4: begin
        if      (k == 8'd22) begin f = 1'b1; d = 4'd4; end
        else if (k == 8'd24) begin f = 1'b1; d = 4'd5; end
        else if (k == 8'd26) begin f = 1'b1; d = 4'd6; end
      end
      16'd6: n = 8'd6;
      default: ;
    endcase
  endtask

  always_comb bank(idx_address,  idx_key,  idx_found,  idx_data,  idx_node);
  always_comb bank(idx_address2, idx_key2, idx_found2, idx_data2, idx_node2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_result(input string tag, input logic f, input logic [3:0] d,
                              input logic [3:0] s, input logic o);
    check({tag, "_done"},     32'(done),     32'd1);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_found"},    32'(found),    32'(f));
    check({tag, "_data"},     32'(data),     32'(d));
    check({tag, "_steps"},    32'(steps),    32'(s));
    check({tag, "_overflow"}, 32'(overflow), 32'(o));
    check({tag, "_addr0"},    32'(idx_address), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; key = 8'd0; start2 = 1'b0; key2 = 8'd0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_steps", 32'(steps), 32'd0);
    check("rst_idxkey", 32'(idx_key), 32'd0);
    check("rst_idxaddr", 32'(idx_address), 32'd0);
    reset = 1'b1;

    // Root hit: key 20.
    tick();
    start = 1'b1; key = 8'd20;
    tick();
    start = 1'b0; key = 8'd0;
    check("root_busy", 32'(busy), 32'd1);
    check("root_addr", 32'(idx_address), 32'd1);
    check("root_idxkey", 32'(idx_key), 32'd20);
    tick();
    check_result("root", 1'b1, 4'd2, 4'd1, 1'b0);
    tick();
    check("root_done_pulse", 32'(done), 32'd0);
    check("root_found_held", 32'(found), 32'd1);
    check("root_data_held", 32'(data), 32'd2);

    // Two-level hit: key 15, with an ignored start (key 10) mid-search.
    start = 1'b1; key = 8'd15;
    tick();
    key = 8'd10;
    check("two_addr1", 32'(idx_address), 32'd1);
    tick();
    start = 1'b0; key = 8'd0;
    check("two_addr3", 32'(idx_address), 32'd3);
    check("two_idxkey_kept", 32'(idx_key), 32'd15);
    check("two_busy", 32'(busy), 32'd1);
    tick();
    check_result("two", 1'b1, 4'd8, 4'd2, 1'b0);

    // Back-to-back start in the done cycle: key 30.
    start = 1'b1; key = 8'd30;
    tick();
    start = 1'b0; key = 8'd0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_addr", 32'(idx_address), 32'd1);
    check("b2b_idxkey", 32'(idx_key), 32'd30);
    tick();
    check_result("b2b", 1'b1, 4'd3, 4'd1, 1'b0);

    // Miss at leaf: key 25 goes 1 -> 4 -> null.
    tick();
    start = 1'b1; key = 8'd25;
    tick();
    start = 1'b0;
    check("miss_addr1", 32'(idx_address), 32'd1);
    check("miss_found_held", 32'(found), 32'd1);
    tick();
    check("miss_addr4", 32'(idx_address), 32'd4);
    tick();
    check_result("miss", 1'b0, 4'd0, 4'd2, 1'b0);

    // Overflow on the self-looping tree rooted at node 6.
    tick();
    start2 = 1'b1; key2 = 8'd7;
    tick();
    start2 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check("ovf_busy", 32'(busy2), 32'd1);
      check("ovf_addr", 32'(idx_address2), 32'd6);
      tick();
      check("ovf_no_done", 32'(done2), 32'd0);
    end
    tick();
    check("ovf_done", 32'(done2), 32'd1);
    check("ovf_found", 32'(found2), 32'd0);
    check("ovf_data", 32'(data2), 32'd0);
    check("ovf_steps", 32'(steps2), 32'd8);
    check("ovf_overflow", 32'(overflow2), 32'd1);

    // Reset mid-search during the second probe of key 15.
    tick();
    start = 1'b1; key = 8'd15;
    tick();
    start = 1'b0;
    tick();
    check("rmid_addr3", 32'(idx_address), 32'd3);
    #3 reset = 1'b0;
    #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    check("rmid_found", 32'(found), 32'd0);
    check("rmid_data", 32'(data), 32'd0);
    check("rmid_steps", 32'(steps), 32'd0);
    check("rmid_idxkey", 32'(idx_key), 32'd0);
    check("rmid_idxaddr", 32'(idx_address), 32'd0);
    tick();
    check("rmid_no_done", 32'(done), 32'd0);
    #3 reset = 1'b1;
    tick();
    check("rmid_idle_done", 32'(done), 32'd0);
    start = 1'b1; key = 8'd20;
    tick();
    start = 1'b0;
    check("post_addr", 32'(idx_address), 32'd1);
    tick();
    check_result("post", 1'b1, 4'd2, 4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
